// File: rtl/decode_fetchq_if.sv
// Fetch-to-decode parcel queue bus: fetch push side, decoder pop side, flush and fill level.
interface decode_fetchq_if #(
  parameter int unsigned RV    = 32,
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic          flush;
  logic [RV-1:0] flush_pc;
  logic          in_valid;
  logic [15:0]   in_ins;
  logic          in_ready;
  logic          out_valid;
  logic [15:0]   out_ins;
  logic [15:0]   out_ins2;
  logic [RV-1:0] out_pc;
  logic          out_fused;
  logic          out_ready;
  logic [CW-1:0] count;

  // Fetch/decode side driving the queue.
  modport master (
    output flush, flush_pc, in_valid, in_ins, out_ready,
    input  in_ready, out_valid, out_ins, out_ins2, out_pc, out_fused, count
  );

  // The queue itself.
  modport slave (
    input  flush, flush_pc, in_valid, in_ins, out_ready,
    output in_ready, out_valid, out_ins, out_ins2, out_pc, out_fused, count
  );
endinterface

// File: rtl/decode_fetchq.sv
// Instruction-parcel ring queue between fetch and decode with optional lui+addi fusion.
module decode_fetchq #(
  parameter int unsigned   RV       = 32,
  parameter int unsigned   DEPTH    = 4,
  parameter int unsigned   FUSE     = 1,
  parameter int unsigned   HOLD     = 2,
  parameter logic [RV-1:0] RESET_PC = '0
) (
  input logic            clk,
  input logic            reset,
  decode_fetchq_if.slave q
);

  localparam int unsigned PW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW        = $clog2(DEPTH + 1);
  localparam int unsigned HW        = (HOLD > 0) ? $clog2(HOLD + 1) : 1;
  localparam int unsigned HOLD_LAST = (HOLD > 0) ? HOLD - 1 : 0;

  typedef enum logic {S_NORMAL, S_WAIT} state_t;

  logic [15:0]   mem_q [DEPTH];
  logic [PW-1:0] head_q, tail_q;
  logic [CW-1:0] count_q;
  logic [RV-1:0] pc_q;
  state_t        state_q, state_d;
  logic [HW-1:0] hold_q, hold_d;

  logic [PW-1:0] second_ptr, head_pop;
  logic [15:0]   head_ins, next_ins, nxt_head_ins;
  logic          fused_c, valid_c, in_ready_c, push, pop, enter_wait;
  logic [1:0]    pop_n;
  logic [CW-1:0] count_d, remain;

  // Ring pointer advance by k (k <= 2), wrapping at DEPTH.
  function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] p, input logic [1:0] k);
    int unsigned s;
    s = 32'(p) + 32'(k);
    if (s >= DEPTH) s = s - DEPTH;
    return PW'(s);
  endfunction

  // lui into x8..x15, or a 32-bit opcode sharing the same upper bits.
  function automatic logic is_cand(input logic [15:0] h);
    return (FUSE != 0) && (h[15:13] == 3'b011) && h[10] && h[0];
  endfunction

  // addi writing the same register as the lui at the head.
  function automatic logic is_pair(input logic [15:0] h, input logic [15:0] n);
    return (n[1:0] == 2'b01) && (n[15:13] == 3'b000) && ({1'b1, n[9:7]} == h[10:7]);
  endfunction

  // Head decode, handshakes and next fill level.
  always_comb begin
    second_ptr   = wrap_add(head_q, 2'd1);
    head_ins     = mem_q[head_q];
    next_ins     = mem_q[second_ptr];
    fused_c      = (count_q >= CW'(2)) && is_cand(head_ins) && is_pair(head_ins, next_ins);
    valid_c      = (count_q != '0) && (state_q != S_WAIT);
    in_ready_c   = !reset && !q.flush && (count_q < CW'(DEPTH));
    push         = q.in_valid && in_ready_c;
    pop          = valid_c && q.out_ready && !q.flush && !reset;
    pop_n        = pop ? (fused_c ? 2'd2 : 2'd1) : 2'd0;
    remain       = count_q - CW'(pop_n);
    count_d      = remain + CW'(push);
    head_pop     = wrap_add(head_q, pop_n);
    nxt_head_ins = (remain != '0) ? mem_q[head_pop] : q.in_ins;
    // Stall only a candidate that has just arrived at the head alone.
    enter_wait   = (HOLD > 0) && (pop || (count_q == '0)) && (count_d == CW'(1)) &&
                   is_cand(nxt_head_ins);
  end

  // Stall FSM next state: wait for the addi parcel for at most HOLD cycles.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    case (state_q)
      S_NORMAL: begin
        if (enter_wait) begin
          state_d = S_WAIT;
          hold_d  = '0;
        end
      end
      S_WAIT: begin
        if ((count_d >= CW'(2)) || (hold_q == HW'(HOLD_LAST))) begin
          state_d = S_NORMAL;
          hold_d  = '0;
        end else begin
          hold_d = hold_q + HW'(1);
        end
      end
      default: begin
        state_d = S_NORMAL;
        hold_d  = '0;
      end
    endcase
    if (q.flush) begin
      state_d = S_NORMAL;
      hold_d  = '0;
    end
  end

  // Stall FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_NORMAL;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
    end
  end

  // Storage, pointers, fill level and head PC.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[PW'(i)] <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      pc_q    <= RESET_PC;
    end else if (q.flush) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      pc_q    <= q.flush_pc;
    end else begin
      if (push) begin
        mem_q[tail_q] <= q.in_ins;
        tail_q        <= wrap_add(tail_q, 2'd1);
      end
      if (pop) begin
        head_q <= head_pop;
        pc_q   <= pc_q + (fused_c ? RV'(4) : RV'(2));
      end
      count_q <= count_d;
    end
  end

  assign q.in_ready  = in_ready_c;
  assign q.out_valid = valid_c;
  assign q.out_ins   = head_ins;
  assign q.out_ins2  = (count_q >= CW'(2)) ? next_ins : 16'h0000;
  assign q.out_pc    = pc_q;
  assign q.out_fused = fused_c;
  assign q.count     = count_q;

endmodule

// File: tb/tb_decode_fetchq.sv
// Bench for decode_fetchq: a fusing instance and a non-fusing instance share stimulus.
module tb_decode_fetchq;
  localparam int unsigned RV    = 32;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = $clog2(DEPTH + 1);
  localparam int          D     = int'(DEPTH);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic          flush;
  logic [RV-1:0] flush_pc;
  logic          in_valid;
  logic [15:0]   in_ins;
  logic          out_ready;

  decode_fetchq_if #(.RV(RV), .DEPTH(DEPTH)) bus0 ();
  decode_fetchq_if #(.RV(RV), .DEPTH(DEPTH)) bus1 ();

  assign bus0.flush = flush;  assign bus0.flush_pc = flush_pc;
  assign bus0.in_valid = in_valid;  assign bus0.in_ins = in_ins;  assign bus0.out_ready = out_ready;
  assign bus1.flush = flush;  assign bus1.flush_pc = flush_pc;
  assign bus1.in_valid = in_valid;  assign bus1.in_ins = in_ins;  assign bus1.out_ready = out_ready;

  decode_fetchq #(.RV(RV), .DEPTH(DEPTH), .FUSE(1), .HOLD(2), .RESET_PC(32'h0))
    u_dut0 (.clk(clk), .reset(reset), .q(bus0));
  decode_fetchq #(.RV(RV), .DEPTH(DEPTH), .FUSE(0), .HOLD(0), .RESET_PC(32'h100))
    u_dut1 (.clk(clk), .reset(reset), .q(bus1));

  logic          o_valid [2], o_ready [2], o_fused [2];
  logic [15:0]   o_ins [2], o_ins2 [2];
  logic [RV-1:0] o_pc [2];
  logic [CW-1:0] o_cnt [2];
  assign o_valid[0] = bus0.out_valid;  assign o_valid[1] = bus1.out_valid;
  assign o_ready[0] = bus0.in_ready;   assign o_ready[1] = bus1.in_ready;
  assign o_fused[0] = bus0.out_fused;  assign o_fused[1] = bus1.out_fused;
  assign o_ins[0]   = bus0.out_ins;    assign o_ins[1]   = bus1.out_ins;
  assign o_ins2[0]  = bus0.out_ins2;   assign o_ins2[1]  = bus1.out_ins2;
  assign o_pc[0]    = bus0.out_pc;     assign o_pc[1]    = bus1.out_pc;
  assign o_cnt[0]   = bus0.count;      assign o_cnt[1]   = bus1.count;

  int unsigned checks = 0;
  int unsigned failures = 0;
  int unsigned cyc = 0;

  // Reference model: per instance, an in-order parcel list (index 0 = head).
  logic [15:0]   mbuf [2][DEPTH];
  int            mcnt [2];
  logic [RV-1:0] mpc [2];
  int            mstall [2];

  function automatic int fuse_of(input int i); return (i == 0) ? 1 : 0; endfunction
  function automatic int hold_of(input int i); return (i == 0) ? 2 : 0; endfunction
  function automatic logic [RV-1:0] rpc_of(input int i); return (i == 0) ? 32'h0 : 32'h100; endfunction

  function automatic bit lui_like(input logic [15:0] h);
    return (h[15:13] == 3'b011) && h[10] && ((h[1:0] == 2'b01) || (h[1:0] == 2'b11));
  endfunction

  function automatic bit addi_for(input logic [15:0] h, input logic [15:0] n);
    return (n[1:0] == 2'b01) && (n[15:13] == 3'b000) && ({1'b1, n[9:7]} == h[10:7]);
  endfunction

  function automatic bit m_fused(input int i);
    return (fuse_of(i) != 0) && (mcnt[i] >= 2) && lui_like(mbuf[i][0]) &&
           addi_for(mbuf[i][0], mbuf[i][1]);
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      mcnt[i] = 0;  mpc[i] = rpc_of(i);  mstall[i] = 0;
      for (int k = 0; k < D; k++) mbuf[i][k] = 16'h0;
    end
  endtask

  task automatic check_outputs();
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("u%0d.count", i), 64'(o_cnt[i]), 64'(mcnt[i]));
      chk($sformatf("u%0d.out_valid", i), 64'(o_valid[i]), 64'((mcnt[i] > 0) && (mstall[i] == 0)));
      chk($sformatf("u%0d.in_ready", i), 64'(o_ready[i]), 64'(!flush && (mcnt[i] < D)));
      chk($sformatf("u%0d.out_pc", i), 64'(o_pc[i]), 64'(mpc[i]));
      chk($sformatf("u%0d.out_fused", i), 64'(o_fused[i]), 64'(m_fused(i)));
      chk($sformatf("u%0d.out_ins2", i), 64'(o_ins2[i]), 64'((mcnt[i] >= 2) ? mbuf[i][1] : 16'h0));
      if (mcnt[i] > 0) chk($sformatf("u%0d.out_ins", i), 64'(o_ins[i]), 64'(mbuf[i][0]));
    end
  endtask

  // Advance the model by one clock using the inputs held across that edge.
  task automatic model_step();
    for (int i = 0; i < 2; i++) begin
      if (flush) begin
        mcnt[i] = 0;  mpc[i] = flush_pc;  mstall[i] = 0;
      end else begin
        bit v, f, was_empty, stalled, pop, rdy;
        int n;
        v         = (mcnt[i] > 0) && (mstall[i] == 0);
        f         = m_fused(i);
        was_empty = (mcnt[i] == 0);
        stalled   = (mstall[i] > 0);
        rdy       = (mcnt[i] < D);
        pop       = v && out_ready;
        if (pop) begin
          n = f ? 2 : 1;
          for (int k = 0; k < D; k++) mbuf[i][k] = (k + n < D) ? mbuf[i][k + n] : 16'h0;
          mcnt[i] = mcnt[i] - n;
          mpc[i]  = mpc[i] + RV'(2 * n);
        end
        if (in_valid && rdy) begin
          mbuf[i][mcnt[i]] = in_ins;
          mcnt[i]++;
        end
        if (stalled) mstall[i] = (mcnt[i] >= 2) ? 0 : mstall[i] - 1;
        else if ((fuse_of(i) != 0) && (hold_of(i) > 0) && (pop || was_empty) &&
                 (mcnt[i] == 1) && lui_like(mbuf[i][0]))
          mstall[i] = hold_of(i);
      end
    end
  endtask

  task automatic cycle(input logic fl, input logic [RV-1:0] fpc, input logic iv,
                       input logic [15:0] ii, input logic ordy);
    flush = fl;  flush_pc = fpc;  in_valid = iv;  in_ins = ii;  out_ready = ordy;
    #1;
    check_outputs();
    @(posedge clk);
    model_step();
    cyc++;
    #1;
  endtask

  function automatic logic [15:0] rand_parcel();
    logic [15:0] p;
    p = 16'($urandom);
    case ($urandom_range(0, 3))
      0: begin p[15:13] = 3'b011; p[10] = 1'b1; p[0] = 1'b1; p[9:8] = 2'b00; end
      1: begin p[15:13] = 3'b000; p[1:0] = 2'b01; p[9:8] = 2'b00; end
      default: ;
    endcase
    return p;
  endfunction

  initial begin
    reset = 1'b1;  flush = 1'b0;  flush_pc = '0;
    in_valid = 1'b1;  in_ins = 16'h1234;  out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    chk("rst.in_ready", 64'(bus0.in_ready), 64'(0));
    chk("rst.out_ins", 64'(bus0.out_ins), 64'(0));
    reset = 1'b0;  in_valid = 1'b0;

    // Single parcel, then pop.
    cycle(1'b0, '0, 1'b1, 16'h0021, 1'b0);
    chk("t1.valid", 64'(bus0.out_valid), 64'(1));
    chk("t1.ins", 64'(bus0.out_ins), 64'h0021);
    chk("t1.pc", 64'(bus0.out_pc), 64'h0);
    chk("t1.count", 64'(bus0.count), 64'(1));
    cycle(1'b0, '0, 1'b0, 16'h0, 1'b1);

    // lui+addi back to back: one fused pop.
    cycle(1'b0, '0, 1'b1, 16'h6401, 1'b1);
    cycle(1'b0, '0, 1'b1, 16'h0021, 1'b1);
    chk("t2.fused", 64'(bus0.out_fused), 64'(1));
    chk("t2.ins2", 64'(bus0.out_ins2), 64'h0021);
    chk("t2.count", 64'(bus0.count), 64'(2));
    cycle(1'b0, '0, 1'b0, 16'h0, 1'b1);
    chk("t2.pc", 64'(bus0.out_pc), 64'h6);
    chk("t2.count0", 64'(bus0.count), 64'(0));
    chk("t2.nofuse_pc", 64'(bus1.out_pc), 64'h106);

    // Lone lui: stall two cycles then issue unfused.
    cycle(1'b0, '0, 1'b1, 16'h6401, 1'b1);
    chk("t3.stall1", 64'(bus0.out_valid), 64'(0));
    cycle(1'b0, '0, 1'b0, 16'h0, 1'b1);
    chk("t3.stall2", 64'(bus0.out_valid), 64'(0));
    cycle(1'b0, '0, 1'b0, 16'h0, 1'b1);
    chk("t3.issue", 64'(bus0.out_valid), 64'(1));
    chk("t3.unfused", 64'(bus0.out_fused), 64'(0));
    cycle(1'b0, '0, 1'b0, 16'h0, 1'b1);

    // Lone lui, addi arrives during the stall.
    cycle(1'b0, '0, 1'b1, 16'h6401, 1'b1);
    cycle(1'b0, '0, 1'b1, 16'h0021, 1'b1);
    chk("t4.fused", 64'(bus0.out_fused), 64'(1));
    chk("t4.valid", 64'(bus0.out_valid), 64'(1));
    cycle(1'b0, '0, 1'b0, 16'h0, 1'b1);

    // Fill, then pop at full and push+pop below full across the wrap.
    cycle(1'b0, '0, 1'b1, 16'h1111, 1'b0);
    cycle(1'b0, '0, 1'b1, 16'h2222, 1'b0);
    cycle(1'b0, '0, 1'b1, 16'h3333, 1'b0);
    cycle(1'b0, '0, 1'b1, 16'h4444, 1'b0);
    chk("t5.full_count", 64'(bus0.count), 64'(4));
    chk("t5.full_ready", 64'(bus0.in_ready), 64'(0));
    cycle(1'b0, '0, 1'b1, 16'h5555, 1'b1);
    chk("t5.pop_at_full", 64'(bus0.count), 64'(3));
    cycle(1'b0, '0, 1'b1, 16'h6666, 1'b1);
    chk("t5.pushpop_count", 64'(bus0.count), 64'(3));
    chk("t5.pushpop_head", 64'(bus0.out_ins), 64'h3333);
    repeat (4) cycle(1'b0, '0, 1'b0, 16'h0, 1'b1);

    // Flush during a stall with a parcel offered.
    cycle(1'b0, '0, 1'b1, 16'h6401, 1'b0);
    cycle(1'b1, 32'h1000, 1'b1, 16'h0021, 1'b1);
    chk("t6.count", 64'(bus0.count), 64'(0));
    chk("t6.valid", 64'(bus0.out_valid), 64'(0));
    chk("t6.pc", 64'(bus0.out_pc), 64'h1000);
    cycle(1'b0, '0, 1'b0, 16'h0, 1'b1);

    // Randomized traffic against the model.
    for (int t = 0; t < 3000; t++) begin
      cycle(($urandom_range(0, 59) == 0), RV'($urandom) & ~RV'(1),
            ($urandom_range(0, 9) < 6), rand_parcel(), ($urandom_range(0, 9) < 7));
    end
    cycle(1'b0, '0, 1'b0, 16'h0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
